// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, zero-register constant and port-slicing helper for regfile_sb
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam int REG_ZERO = 0;
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/sb_busy_table.sv
// sb_busy_table: per-register busy bits with flush > issue > write-back priority and registered busy count
// Ports: clk, res (async active-low), iss_valid/iss_rd (set), wb_valid/wb_rd (clear),
//        flush (clear all), busy (per-register bits), busy_cnt (popcount of busy)
module sb_busy_table
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW-1:0]    busy_cnt
);
  logic [NREGS-1:0] busy_nxt;
  logic [AW-1:0]    cnt_nxt;
  // later assignments win, so ordering encodes wb-clear < issue-set < flush;
  // register 0 is never busy, which keeps the count within AW bits
  always_comb begin
    busy_nxt = busy;
    if (wb_valid && wb_rd != AW'(REG_ZERO)) busy_nxt[wb_rd] = 1'b0;
    if (iss_valid && iss_rd != AW'(REG_ZERO)) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[REG_ZERO] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + AW'(busy_nxt[i]);
  end
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NRD combinational read ports, one write-back port and a RAW scoreboard
// Ports: clk, res (async active-low), rd_addr/rd_data/rd_busy (NRD packed read ports),
//        iss_valid/iss_rd (mark destination pending), wb_valid/wb_rd/wb_data (write and clear),
//        flush (clear all busy bits), busy_cnt (registered number of busy registers)
// Option: define REGFILE_BYPASS_EN to forward same-cycle write-back data to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = NRD_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [AW-1:0]     busy_cnt
);
  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb_we;
  assign wb_we = wb_valid && wb_rd != AW'(REG_ZERO);
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wb_we) begin
      mem[wb_rd] <= wb_data;
    end
  sb_busy_table #(.NREGS(NREGS), .AW(AW)) u_busy (
    .clk(clk),
    .res(res),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .flush(flush),
    .busy(busy),
    .busy_cnt(busy_cnt)
  );
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero;
    assign addr = rd_addr[slice_lo(k, AW) +: AW];
    assign zero = addr == AW'(REG_ZERO);
`ifdef REGFILE_BYPASS_EN
    logic byp;
    assign byp = wb_we && wb_rd == addr;
    assign rd_data[slice_lo(k, XLEN) +: XLEN] = zero ? '0 : byp ? wb_data : mem[addr];
    assign rd_busy[k] = !zero && !byp && busy[addr];
`else
    assign rd_data[slice_lo(k, XLEN) +: XLEN] = zero ? '0 : mem[addr];
    assign rd_busy[k] = !zero && busy[addr];
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb against an array-based reference model
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;
  logic                clk = 1'b0;
  logic                res = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       iss_rd = '0;
  logic                wb_valid = 1'b0;
  logic [AW-1:0]       wb_rd = '0;
  logic [XLEN-1:0]     wb_data = '0;
  logic                flush = 1'b0;
  logic [AW-1:0]       busy_cnt;
  always #5 clk = ~clk;
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .res(res), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .busy_cnt(busy_cnt)
  );
  typedef struct {
    string               nm;
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0]      b;
    logic [AW-1:0]       c;
  } exp_t;
  exp_t q[$];
  event ev;
  int tests = 0;
  int fails = 0;
  logic [XLEN-1:0] mem_m [NREGS];
  bit              busy_m [NREGS];
  function automatic exp_t predict(string nm);
    exp_t e;
    int n = 0;
    logic [AW-1:0] a;
    e.nm = nm;
    e.d = '0;
    e.b = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      if (a != 0) begin
        e.d[k*XLEN +: XLEN] = mem_m[a];
        e.b[k] = busy_m[a];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && wb_rd != 0 && wb_rd == a) begin
          e.d[k*XLEN +: XLEN] = wb_data;
          e.b[k] = 1'b0;
        end
`endif
      end
    end
    for (int i = 0; i < NREGS; i++) n += int'(busy_m[i]);
    e.c = AW'(n);
    return e;
  endfunction
  initial forever begin
    exp_t e;
    @(ev);
    while (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      if (rd_data !== e.d) begin
        fails++;
        $display("FAIL %s rd_data got %h want %h", e.nm, rd_data, e.d);
      end
      tests++;
      if (rd_busy !== e.b) begin
        fails++;
        $display("FAIL %s rd_busy got %b want %b", e.nm, rd_busy, e.b);
      end
      tests++;
      if (busy_cnt !== e.c) begin
        fails++;
        $display("FAIL %s busy_cnt got %0d want %0d", e.nm, busy_cnt, e.c);
      end
    end
  end
  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) begin
      mem_m[i] = '0;
      busy_m[i] = 1'b0;
    end
  endtask
  task automatic update_model();
    if (wb_valid && wb_rd != 0) mem_m[wb_rd] = wb_data;
    if (flush) begin
      for (int i = 0; i < NREGS; i++) busy_m[i] = 1'b0;
    end else begin
      if (wb_valid && wb_rd != 0) busy_m[wb_rd] = 1'b0;
      if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
    end
  endtask
  task automatic drv(input bit iv, input int ir, input bit wv, input int wr,
                     input logic [XLEN-1:0] wd, input bit fl, input int a0, input int a1);
    iss_valid = iv;
    iss_rd = AW'(ir);
    wb_valid = wv;
    wb_rd = AW'(wr);
    wb_data = wd;
    flush = fl;
    rd_addr = {AW'(a1), AW'(a0)};
  endtask
  task automatic tick(input string nm);
    #1;
    q.push_back(predict(nm));
    ->ev;
    @(posedge clk);
    if (res) update_model();
    @(negedge clk);
  endtask
  task automatic hard_reset(input string nm);
    res = 1'b0;
    clear_model();
    wb_valid = 1'b0;
    #1;
    q.push_back(predict(nm));
    ->ev;
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
  endtask
  initial begin
    clear_model();
    @(negedge clk);
    drv(0, 0, 0, 0, '0, 0, 5, 5);
    hard_reset("reset");
    drv(1, 7, 0, 0, '0, 0, 7, 7);
    tick("iss7");
    drv(0, 0, 0, 0, '0, 0, 7, 7);
    tick("busy7");
    drv(0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 7);
    tick("wb7_bypass");
    drv(0, 0, 0, 0, '0, 0, 7, 7);
    tick("rd7");
    drv(1, 9, 0, 0, '0, 0, 9, 7);
    tick("iss9");
    drv(1, 9, 1, 9, 32'hA5A5_5A5A, 0, 9, 9);
    tick("iss_wb9");
    drv(0, 0, 0, 0, '0, 0, 9, 9);
    tick("chk9");
    drv(1, 0, 1, 0, 32'h1234, 0, 0, 0);
    tick("r0_write");
    drv(0, 0, 0, 0, '0, 0, 0, 9);
    tick("r0_read");
    drv(1, 3, 1, 9, 32'h99, 0, 3, 9);
    tick("iss3");
    drv(1, 4, 0, 0, '0, 0, 3, 4);
    tick("iss4");
    drv(1, 5, 0, 0, '0, 0, 4, 5);
    tick("iss5");
    drv(0, 0, 0, 0, '0, 0, 3, 5);
    tick("cnt3");
    drv(1, 6, 1, 4, 32'h4444, 1, 3, 6);
    tick("flush_iss6");
    drv(0, 0, 0, 0, '0, 0, 4, 6);
    tick("flushed");
    drv(1, 8, 1, 10, 32'hCAFE, 0, 8, 10);
    tick("pre_rst");
    drv(0, 0, 0, 0, '0, 0, 8, 10);
    tick("pre_rst2");
    hard_reset("mid_reset");
    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 2) != 0), $urandom_range(0, NREGS - 1),
          ($urandom_range(0, 2) != 0), $urandom_range(0, NREGS - 1),
          $urandom, ($urandom_range(0, 15) == 0),
          $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 99) == 0) hard_reset("rand_reset");
      else tick("rand");
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in scoreboard for the pipelined RISC core. It provides NRD combinational read ports and one write-back port, and tracks a busy bit per register. Issue marks a destination pending and write-back clears it, so decode can stall on RAW hazards without external bookkeeping. It replaces the fixed 32×32, 2-read register file in the decode stage.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of registers (power of two, ≥ 2); register 0 hard-wired to zero
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), address width (derived, not overridden)

- clk  in  1  rising-edge clock
- res  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  port k source has a pending producer
- iss_valid  in  1  instruction issued this cycle
- iss_rd  in  AW  destination of the issued instruction
- wb_valid  in  1  write-back this cycle
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back data
- flush  in  1  synchronous clear of all busy bits (pipeline flush)
- busy_cnt  out  AW  number of registers currently busy (registered)

## Operation
- Storage: NREGS×XLEN array. On reset, all entries are 0, all busy bits are 0, and busy_cnt is 0.
- Write: on a clk edge with wb_valid and wb_rd≠0, mem[wb_rd] ← wb_data. Busy state does not gate the write.
- Issue: on a clk edge with iss_valid and iss_rd≠0, busy[iss_rd] ← 1.
- Write-back clear: on a clk edge with wb_valid and wb_rd≠0, busy[wb_rd] ← 0.
- Same-cycle issue and write-back to the same register: busy stays 1, because the new producer wins.
- Issue to an already-busy register (WAW): busy stays 1 and busy_cnt is unchanged.
- Write-back to a non-busy register: data is written and busy_cnt is unchanged.
- flush: clears all busy bits and busy_cnt on the next edge. It overrides issue in the same cycle. A write-back in the same cycle still writes its data.
- busy_cnt: registered. It equals the population count of the busy bits after each edge and saturates by construction at NREGS-1.
- Register 0:
  - rd_data is always 0 and rd_busy is always 0.
  - Writes and issues to register 0 are ignored.
- Read ports are fully combinational from rd_addr.

## Timing
- Write and busy updates take effect at the clk edge. Without bypass, a stored value is visible on rd_data the cycle after the write.
- rd_busy and rd_data are combinational, with no added latency.
- Reset mid-operation clears data, busy bits and busy_cnt immediately, independent of clk. Outputs reflect zeros while res is low.
- Simultaneous events on one edge are resolved in this priority: flush > issue set > write-back clear.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose rd_addr matches wb_rd (wb_valid, ≠0) returns wb_data in the same cycle.
  - That port's rd_busy is forced to 0 in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - rd_data comes from the array only.
  - rd_busy comes from the registered busy bits, so the consumer stalls one extra cycle after write-back.

## Structure
- Shared package regfile_pkg holds the XLEN/NREGS defaults, the port-slicing helpers, and the zero-register constant REG_ZERO.
- One sub-module, sb_busy_table, holds the busy bits, the issue/wb/flush priority logic and the busy_cnt register.
- The data array and read muxes stay in regfile_sb.

## Test plan
- Reset: hold res low, drive rd_addr=5 → rd_data=0, rd_busy=0, busy_cnt=0.
- Issue/write-back: issue rd=7; next cycle rd_busy(7)=1 and busy_cnt=1. Write back 0xDEADBEEF to 7, then read 7 → 0xDEADBEEF, busy 0, busy_cnt=0.
- Bypass: in the write-back cycle, read port 1 addr=7:
  - With REGFILE_BYPASS_EN: rd_data=0xDEADBEEF, rd_busy=0.
  - Without: old value and rd_busy=1.
- Same-cycle issue+wb to 9, with 9 previously busy → busy remains 1, busy_cnt unchanged, mem[9] updated.
- Register 0: issue and write back 0x1234 to 0 → rd_data(0)=0, busy_cnt=0.
- Flush: issue 3,4,5 (busy_cnt=3), then flush together with issue 6 → busy_cnt=0, all rd_busy=0. Assert res low mid-sequence → immediate zeros.
